// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg
// Shared definitions for the ALU writeback stage: fcode opcodes, branch
// condition encodings, flag bit positions and small opcode-decode helpers.
// No ports (package).
package alu_writeback_pkg;

  // ALU opcodes carried on fcode
  localparam logic [3:0] FC_ADD = 4'b0000;
  localparam logic [3:0] FC_SUB = 4'b0001;
  localparam logic [3:0] FC_AND = 4'b0010;
  localparam logic [3:0] FC_OR  = 4'b0011;
  localparam logic [3:0] FC_XOR = 4'b0100;
  localparam logic [3:0] FC_CMP = 4'b0101;
  localparam logic [3:0] FC_MOV = 4'b1000;

  // Branch condition selects; 13..15 never taken
  localparam logic [3:0] CC_AL  = 4'd0;
  localparam logic [3:0] CC_EQ  = 4'd1;
  localparam logic [3:0] CC_NE  = 4'd2;
  localparam logic [3:0] CC_LT  = 4'd3;
  localparam logic [3:0] CC_GE  = 4'd4;
  localparam logic [3:0] CC_LTU = 4'd5;
  localparam logic [3:0] CC_GEU = 4'd6;
  localparam logic [3:0] CC_MI  = 4'd7;
  localparam logic [3:0] CC_PL  = 4'd8;
  localparam logic [3:0] CC_VS  = 4'd9;
  localparam logic [3:0] CC_VC  = 4'd10;
  localparam logic [3:0] CC_GT  = 4'd11;
  localparam logic [3:0] CC_LE  = 4'd12;

  // Flag bit positions within {S,Z,C,V}
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    FL_NONE,   // flags untouched
    FL_ARITH,  // all four flags from the ALU code
    FL_LOGIC   // S,Z from code, C cleared, V kept
  } flag_upd_e;

  function automatic logic writes_reg(input logic [3:0] fc);
    case (fc)
      FC_ADD, FC_SUB, FC_AND, FC_OR, FC_XOR, FC_MOV: writes_reg = 1'b1;
      default:                                       writes_reg = 1'b0;
    endcase
  endfunction

  function automatic flag_upd_e flag_update(input logic [3:0] fc);
    case (fc)
      FC_ADD, FC_SUB, FC_CMP:         flag_update = FL_ARITH;
      FC_AND, FC_OR, FC_XOR, FC_MOV:  flag_update = FL_LOGIC;
      default:                        flag_update = FL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_writeback_cond_eval.sv
// cond_eval
// Purely combinational branch-condition evaluator.
// Ports:
//   flags : in  {S,Z,C,V} architectural flags
//   cond  : in  condition select
//   taken : out condition holds for the given flags
module cond_eval
  import alu_writeback_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       taken
);

  logic s, z, c, v;

  assign s = flags[FLAG_S];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_AL:   taken = 1'b1;
      CC_EQ:   taken = z;
      CC_NE:   taken = !z;
      CC_LT:   taken = s ^ v;
      CC_GE:   taken = !(s ^ v);
      CC_LTU:  taken = c;
      CC_GEU:  taken = !c;
      CC_MI:   taken = s;
      CC_PL:   taken = !s;
      CC_VS:   taken = v;
      CC_VC:   taken = !v;
      CC_GT:   taken = !z && !(s ^ v);
      CC_LE:   taken = z || (s ^ v);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback
// Single-entry writeback register in front of an 8 x DW register file and
// the {S,Z,C,V} flag register. An op is accepted into the writeback
// register, then commits (updates architectural state) on the first edge
// where wb_hold is low. Commit and accept may overlap for full throughput.
// Build option: ALU_WB_BYPASS_EN forwards a committing result onto the
// read ports in its commit cycle.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake for result/code/fcode/rd
//   result, code       : ALU result and {s,z,c,v} code
//   fcode, rd          : ALU opcode, destination register
//   wb_hold            : freezes the writeback register
//   ra_addr/ra_data    : read port a
//   rb_addr/rb_data    : read port b
//   flags              : architectural flags {S,Z,C,V}
//   cond/taken         : branch condition select and its result
//   commit             : high in the cycle a writeback commits
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] result,
  input  logic [3:0]    code,
  input  logic [3:0]    fcode,
  input  logic [2:0]    rd,
  input  logic          wb_hold,
  input  logic [2:0]    ra_addr,
  input  logic [2:0]    rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  output logic [3:0]    flags,
  input  logic [3:0]    cond,
  output logic          taken,
  output logic          commit
);

  logic          wb_valid;
  logic [DW-1:0] wb_result;
  logic [3:0]    wb_code;
  logic [3:0]    wb_fcode;
  logic [2:0]    wb_rd;
  logic [3:0]    flags_q;
  logic [DW-1:0] regs [8];
  logic          accept;

  assign in_ready = !wb_valid || !wb_hold;
  assign commit   = wb_valid && !wb_hold;
  assign accept   = in_valid && in_ready;
  assign flags    = flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      flags_q  <= 4'b0000;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (commit) begin
        if (writes_reg(wb_fcode)) regs[wb_rd] <= wb_result;
        case (flag_update(wb_fcode))
          FL_ARITH: flags_q <= wb_code;
          FL_LOGIC: flags_q <= {wb_code[FLAG_S], wb_code[FLAG_Z], 1'b0, flags_q[FLAG_V]};
          default:  ;
        endcase
      end
      // A new accept refills the entry in the same edge the old one commits
      if (accept) begin
        wb_valid  <= 1'b1;
        wb_result <= result;
        wb_code   <= code;
        wb_fcode  <= fcode;
        wb_rd     <= rd;
      end else if (commit) begin
        wb_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU_WB_BYPASS_EN
  logic bypass_ok;
  assign bypass_ok = commit && writes_reg(wb_fcode);
  assign ra_data   = (bypass_ok && (ra_addr == wb_rd)) ? wb_result : regs[ra_addr];
  assign rb_data   = (bypass_ok && (rb_addr == wb_rd)) ? wb_result : regs[rb_addr];
`else
  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
`endif

  cond_eval u_cond_eval (
    .flags (flags_q),
    .cond  (cond),
    .taken (taken)
  );

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] result;
  logic [3:0]    code;
  logic [3:0]    fcode;
  logic [2:0]    rd;
  logic          wb_hold;
  logic [2:0]    ra_addr;
  logic [2:0]    rb_addr;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic [3:0]    flags;
  logic [3:0]    cond;
  logic          taken;
  logic          commit;

  alu_writeback #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .result   (result),
    .code     (code),
    .fcode    (fcode),
    .rd       (rd),
    .wb_hold  (wb_hold),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .flags    (flags),
    .cond     (cond),
    .taken    (taken),
    .commit   (commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  fc;
    logic [3:0]  code;
    logic [2:0]  rd;
    logic [15:0] res;
    logic [3:0]  cond_a;
    logic        exp_a;
    logic [3:0]  cond_b;
    logic        exp_b;
    logic [3:0]  exp_flags;
    logic [15:0] exp_reg;
  } vec_t;

  typedef struct {
    logic [3:0]  fc;
    logic [3:0]  code;
    logic [2:0]  rd;
    logic [15:0] res;
  } op_t;

  vec_t        vecs [9];
  op_t         sb [$];
  logic [15:0] m_regs [8];
  logic [3:0]  m_flags;
  bit          mon_en = 1'b0;

  // Scoreboard: ops pushed on accept, popped and applied to the model on commit
  initial begin
    op_t o;
    m_flags = 4'b0000;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("mon_flags", flags, m_flags);
        chk("mon_in_ready", in_ready, (sb.size() == 0) || !wb_hold);
        chk("mon_commit", commit, (sb.size() != 0) && !wb_hold);
        if (rst) begin
          sb.delete();
          m_flags = 4'b0000;
          for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        end else begin
          if (commit && sb.size() != 0) begin
            o = sb.pop_front();
            case (o.fc)
              FC_ADD, FC_SUB, FC_CMP:        m_flags = o.code;
              FC_AND, FC_OR, FC_XOR, FC_MOV: m_flags = {o.code[3], o.code[2], 1'b0, m_flags[0]};
              default: ;
            endcase
            if (o.fc inside {FC_ADD, FC_SUB, FC_AND, FC_OR, FC_XOR, FC_MOV})
              m_regs[o.rd] = o.res;
          end
          if (in_valid && in_ready) begin
            o.fc = fcode; o.code = code; o.rd = rd; o.res = result;
            sb.push_back(o);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Offer one op and wait (bounded) for it to be taken; returns 1 ns after the accept edge
  task automatic send_op(input logic [3:0] f, input logic [3:0] c, input logic [2:0] r,
                         input logic [15:0] d);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; fcode = f; code = c; rd = r; result = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_all_regs(input string name);
    for (int i = 0; i < 4; i++) begin
      ra_addr = 3'(i);
      rb_addr = 3'(i + 4);
      #1;
      chk(name, ra_data, m_regs[i]);
      chk(name, rb_data, m_regs[i + 4]);
    end
  endtask

  initial begin
    vec_t v;
    //          fc      code     rd    res       ca  ea    cb     eb    flags    reg
    vecs[0] = '{FC_ADD, 4'b0000, 3'd3, 16'h0005, 4'd0, 1'b1, 4'd2,  1'b1, 4'b0000, 16'h0005};
    vecs[1] = '{FC_SUB, 4'b0011, 3'd2, 16'h1234, 4'd5, 1'b1, 4'd6,  1'b0, 4'b0011, 16'h1234};
    vecs[2] = '{FC_CMP, 4'b0100, 3'd3, 16'h0000, 4'd1, 1'b1, 4'd2,  1'b0, 4'b0100, 16'h0005};
    vecs[3] = '{FC_ADD, 4'b0001, 3'd4, 16'h7FFF, 4'd3, 1'b1, 4'd10, 1'b0, 4'b0001, 16'h7FFF};
    vecs[4] = '{FC_XOR, 4'b1000, 3'd5, 16'h8000, 4'd7, 1'b1, 4'd8,  1'b0, 4'b1001, 16'h8000};
    vecs[5] = '{FC_OR,  4'b0011, 3'd0, 16'h00F0, 4'd4, 1'b0, 4'd9,  1'b1, 4'b0001, 16'h00F0};
    vecs[6] = '{4'b1111,4'b1111, 3'd0, 16'hBEEF, 4'd11,1'b0, 4'd15, 1'b0, 4'b0001, 16'h00F0};
    vecs[7] = '{FC_MOV, 4'b1100, 3'd7, 16'h5555, 4'd12,1'b1, 4'd0,  1'b1, 4'b1101, 16'h5555};
    vecs[8] = '{FC_AND, 4'b0110, 3'd3, 16'h0000, 4'd13,1'b0, 4'd1,  1'b1, 4'b0101, 16'h0000};

    rst = 1'b1; in_valid = 1'b0; result = '0; code = '0; fcode = '0; rd = '0;
    wb_hold = 1'b0; ra_addr = '0; rb_addr = '0; cond = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_commit", commit, 0);
    chk("rst_flags", flags, 4'b0000);
    check_all_regs("rst_regs");
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Table: one op each, read back the destination and two conditions after commit
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      send_op(v.fc, v.code, v.rd, v.res);
      @(posedge clk); #1;
      ra_addr = v.rd; rb_addr = v.rd; cond = v.cond_a;
      @(negedge clk);
      chk($sformatf("vec%0d_flags", i), flags, v.exp_flags);
      chk($sformatf("vec%0d_ra", i), ra_data, v.exp_reg);
      chk($sformatf("vec%0d_rb", i), rb_data, v.exp_reg);
      chk($sformatf("vec%0d_taken_a", i), taken, v.exp_a);
      cond = v.cond_b; #1;
      chk($sformatf("vec%0d_taken_b", i), taken, v.exp_b);
    end

    // Hold for 3 cycles with a second op waiting, then commit + accept together
    @(posedge clk); #1;
    in_valid = 1'b1; fcode = FC_MOV; code = 4'b0000; rd = 3'd1; result = 16'h1111;
    @(posedge clk); #1;
    fcode = FC_ADD; code = 4'b1000; rd = 3'd2; result = 16'h2222; wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_commit", commit, 0);
      @(posedge clk);
    end
    #1 wb_hold = 1'b0;
    @(negedge clk);
    chk("hold_drop_commit", commit, 1);
    chk("hold_drop_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; ra_addr = 3'd1;
    @(negedge clk);
    chk("hold_op1_r1", ra_data, 16'h1111);
    chk("hold_op2_no_bubble", commit, 1);
    @(posedge clk); #1;
    ra_addr = 3'd2;
    @(negedge clk);
    chk("hold_op2_r2", ra_data, 16'h2222);
    chk("hold_op2_flags", flags, 4'b1000);
    chk("hold_idle_commit", commit, 0);

    // Read r1 in the commit cycle of a MOV to it
    send_op(FC_MOV, 4'b0000, 3'd1, 16'hAAAA);
    ra_addr = 3'd1; rb_addr = 3'd1;
    @(negedge clk);
    chk("byp_commit", commit, 1);
`ifdef ALU_WB_BYPASS_EN
    chk("byp_ra_commit_cycle", ra_data, 16'hAAAA);
    chk("byp_rb_commit_cycle", rb_data, 16'hAAAA);
`else
    chk("byp_ra_commit_cycle", ra_data, 16'h1111);
    chk("byp_rb_commit_cycle", rb_data, 16'h1111);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("byp_ra_after", ra_data, 16'hAAAA);
    check_all_regs("model_regs");

    // Reset while an op is pending: discarded, everything cleared
    send_op(FC_ADD, 4'b1111, 3'd5, 16'hDEAD);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_flags", flags, 4'b0000);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_commit", commit, 0);
    check_all_regs("rst2_regs");
    ra_addr = 3'd5; #1;
    chk("rst2_r5", ra_data, 16'h0000);

    repeat (2) @(posedge clk);
    #1 mon_en = 1'b0;
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
